// File: rtl/tpu_pkg.sv
// Shared types for the systolic array front end: activation width, signed
// activation type and the input feeder state encoding.
package tpu_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic signed [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift line carrying one row's activation, valid and switch flag.
// Data is forced to zero on entry whenever valid is low, so bubbles are clean.
module skew_delay_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_switch,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_switch
);

    logic [DATA_WIDTH-1:0] data_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_d   [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [DEPTH-1:0]      switch_q;
    logic [DEPTH-1:0]      switch_d;

    always_comb begin
        data_d[0]   = in_valid ? in_data : '0;
        valid_d[0]  = in_valid;
        switch_d[0] = in_valid && in_switch;
        for (int i = 1; i < DEPTH; i++) begin
            data_d[i]   = data_q[i-1];
            valid_d[i]  = valid_q[i-1];
            switch_d[i] = switch_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q  <= '0;
            switch_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q  <= valid_d;
            switch_q <= switch_d;
        end
    end

    assign out_data   = data_q[DEPTH-1];
    assign out_valid  = valid_q[DEPTH-1];
    assign out_switch = switch_q[DEPTH-1];

endmodule

// File: rtl/systolic_input_feeder.sv
// Skews activation vectors onto the west edge of a systolic array, one extra
// cycle per row, and flags the first vector of each tile as a weight switch.
// Optional tile counter output enabled by defining FEEDER_TILE_CNT_EN.
module systolic_input_feeder
    import tpu_pkg::*;
#(
    parameter int ROWS       = 2,
    parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                       in_last,
    output logic [ROWS*DATA_WIDTH-1:0] out_data,
    output logic [ROWS-1:0]            out_valid,
    output logic [ROWS-1:0]            out_switch
`ifdef FEEDER_TILE_CNT_EN
    ,
    output logic [15:0]                tile_cnt
`endif
);

    localparam int CNT_W = (ROWS > 2) ? $clog2(ROWS) : 1;

    feeder_state_e    state_q;
    feeder_state_e    state_d;
    logic [CNT_W-1:0] drain_cnt_q;
    logic [CNT_W-1:0] drain_cnt_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic             accept;
    logic             tile_first;

    assign accept     = in_valid && in_ready_q;
    assign tile_first = accept && (state_q == ST_IDLE);
    assign in_ready   = in_ready_q;

    // DRAIN holds off upstream for ROWS-1 cycles so the tail rows leave first.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_IDLE, ST_STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        if (ROWS > 1) begin
                            state_d     = ST_DRAIN;
                            drain_cnt_d = CNT_W'(ROWS - 2);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d != ST_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef FEEDER_TILE_CNT_EN
    logic [15:0] tile_cnt_q;
    logic [15:0] tile_cnt_d;
    logic        tile_done;

    always_comb begin
        if (ROWS == 1) begin
            tile_done = accept && in_last;
        end else begin
            tile_done = (state_q == ST_DRAIN) && (state_d == ST_IDLE);
        end
        tile_cnt_d = tile_done ? (tile_cnt_q + 16'd1) : tile_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_cnt_q <= '0;
        end else begin
            tile_cnt_q <= tile_cnt_d;
        end
    end

    assign tile_cnt = tile_cnt_q;
`endif

    // Row r sees every accepted vector (or bubble) r+1 cycles later.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_delay_line #(
            .DEPTH      (r + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_skew (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_data    (in_data[r*DATA_WIDTH +: DATA_WIDTH]),
            .in_valid   (accept),
            .in_switch  (tile_first),
            .out_data   (out_data[r*DATA_WIDTH +: DATA_WIDTH]),
            .out_valid  (out_valid[r]),
            .out_switch (out_switch[r])
        );
    end

endmodule
